ahb_cmd_master: RTL and testbench
=================================

Name: ahb_cmd_master

Overview:
- AHB-Lite initiator that turns a simple valid/ready command stream into pipelined AHB single transfers.
- Returns one response per command, carrying read data and error status.
- Sits between test sequencers or CPU-side glue and the AHB memory/peripheral slaves in the utest bench and SoC fabric.
- Issues back-to-back transfers: each address phase overlaps the previous data phase.

Parameters:
- P_AW, 32, address width (HADDR, cmd_addr).
- P_DW, 32, data width (HWDATA, HRDATA, cmd_wdata, rsp_rdata); 32 or 64.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at edge.
- cmd_addr  in  P_AW  byte address; must be aligned to cmd_size.
- cmd_write  in  1  1=write, 0=read.
- cmd_size  in  3  HSIZE encoding (byte/half/word/dword).
- cmd_wdata  in  P_DW  write data, lane-placed as on the bus.
- rsp_valid  out  1  one-cycle pulse per completed transfer, in command order; no back-pressure.
- rsp_rdata  out  P_DW  HRDATA captured at completion; 0 for writes.
- rsp_err  out  1  transfer ended with ERROR response.
- HADDR  out  P_AW  address phase.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- HWRITE  out  1  write flag.
- HSIZE  out  3  transfer size.
- HBURST  out  3  SINGLE=000, INCR=001.
- HWDATA  out  P_DW  data phase write data.
- HRDATA  in  P_DW  read data.
- HRESP  in  2  00=OKAY, 01=ERROR; others are treated as ERROR.
- HREADY  in  1  bus ready; both phases advance only when high.

Behaviour:
- Reset, synchronous while HRESET=1:
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=SINGLE, HWDATA=0.
  - cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Both pipeline stages emptied. Outstanding transfers are dropped with no response.
- Pipeline stages:
  - A-stage holds the transfer currently in address phase (a_vld); it drives the bus address/control outputs.
  - D-stage holds the transfer currently in data phase (d_vld, d_write, d_wdata); HWDATA = d_wdata while d_vld && d_write.
- cmd_ready = !HRESET && (!a_vld || HREADY) && !err_hold. Combinational, no dependency on cmd_valid.
- Accept edge: the command loads into the A-stage. HTRANS=NONSEQ is driven in the next cycle.
- Edge with HREADY=1:
  - A-stage moves to D-stage; if no command is accepted, A-stage empties.
  - A D-stage transfer completes: next cycle rsp_valid=1, rsp_rdata=HRDATA (read) or 0, rsp_err=(HRESP!=00).
- Edge with HREADY=0: both stages hold. The A-stage's HADDR and control must not change.
- Latency with a zero-wait slave:
  - Accept at edge N; NONSEQ in cycle N+1; data phase in N+2; rsp_valid in N+3.
  - Sustained throughput 1 command per cycle.
- Error, two-cycle response:
  - First cycle (HRESP=ERROR, HREADY=0): the next cycle drives HTRANS=IDLE, but A-stage contents are retained (err_hold=1).
  - After the second cycle (HREADY=1): the errored transfer completes with rsp_err=1, the held A-stage is reissued as NONSEQ, and err_hold clears.
  - No command is lost or reordered.
- HTRANS=IDLE whenever A-stage is empty. HADDR/control keep their last values (no X).
- Misaligned cmd_addr/cmd_size is a caller error; the transfer is issued unchanged.
- HRESET asserted mid-wait-state: the block returns to reset values on that edge regardless of HREADY.

Optional Feature:
- Macro: AHB_MST_SEQ_EN.
- Defined: an accepted command is issued as SEQ with HBURST=INCR when all of the following hold; otherwise NONSEQ/INCR:
  - it immediately follows the previous address phase (no IDLE cycle between);
  - same cmd_write and cmd_size;
  - cmd_addr = previous addr + (1<<size);
  - it does not cross a 1 KB boundary.
  - After an error, a reissued transfer is always NONSEQ.
- Undefined: every transfer is NONSEQ/SINGLE.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HBURST encodings (SINGLE/INCR…);
  - HSIZE encodings;
  - HRESP encodings (OKAY/ERROR/RETRY/SPLIT);
  - the 1 KB boundary constant.
- Single module; no sub-module. The two stage registers are simple enough to live inline.

Test Plan:
- Zero-wait slave; write 0x0000_0010=0xDEADBEEF (word) then read 0x10 back-to-back -> NONSEQ on consecutive cycles; read rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after each accept, rsp_err=0.
- Slave with 3 wait states; 4 queued reads -> HADDR/HTRANS stable while HREADY=0, cmd_ready low during waits, 4 responses in order.
- Slave returns ERROR on address 0x100, followed by a queued read of 0x104 -> cycle after first ERROR cycle shows HTRANS=IDLE; 0x104 reissued NONSEQ; responses err=1 then err=0.
- Byte writes 0x11,0x22 to 0x3 and 0x1 with HSIZE=000, then word read of 0x0 -> rsp_rdata has 0x11 in [31:24] and 0x22 in [15:8].
- HRESET pulsed during a waited data phase -> next cycle HTRANS=IDLE, rsp_valid=0, cmd_ready=0 while reset is high; the first command after reset completes normally.
- AHB_MST_SEQ_EN defined; word writes to 0x3F8,0x3FC,0x400 -> NONSEQ, SEQ, NONSEQ (1 KB crossing), HBURST=INCR throughout.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the 1 KB burst-boundary helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'b000,
        HSIZE_HALF   = 3'b001,
        HSIZE_WORD   = 3'b010,
        HSIZE_DWORD  = 3'b011,
        HSIZE_4WORD  = 3'b100,
        HSIZE_8WORD  = 3'b101,
        HSIZE_16WORD = 3'b110,
        HSIZE_32WORD = 3'b111
    } hsize_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    localparam int unsigned AHB_BOUNDARY_BYTES = 1024;

    // Bursts must not cross this boundary, so SEQ is only legal within one region.
    function automatic logic same_boundary_region(input logic [63:0] a, input logic [63:0] b);
        return (a >> $clog2(AHB_BOUNDARY_BYTES)) == (b >> $clog2(AHB_BOUNDARY_BYTES));
    endfunction

endpackage

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: valid/ready command stream to pipelined AHB-Lite transfers, one response each.
// Optional: define AHB_MST_SEQ_EN to issue address-consecutive commands as SEQ with HBURST=INCR.
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int P_AW = 32,
    parameter int P_DW = 32
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [P_AW-1:0] cmd_addr,
    input  logic            cmd_write,
    input  logic [2:0]      cmd_size,
    input  logic [P_DW-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [P_DW-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [P_AW-1:0] HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [P_DW-1:0] HWDATA,
    input  logic [P_DW-1:0] HRDATA,
    input  logic [1:0]      HRESP,
    input  logic            HREADY
);

    logic            a_vld;
    logic [P_AW-1:0] a_addr;
    logic            a_write;
    logic [2:0]      a_size;
    logic [P_DW-1:0] a_wdata;
    logic            d_vld;
    logic            d_write;
    logic [P_DW-1:0] d_wdata;
    logic            err_hold;
    logic            accept;
    logic            d_done;

    assign cmd_ready = !HRESET && (!a_vld || HREADY) && !err_hold;
    assign accept    = cmd_valid && cmd_ready;
    assign d_done    = d_vld && HREADY;

`ifdef AHB_MST_SEQ_EN
    logic a_seq;
    logic a_incr;
    logic seq_ok;

    // The previous address phase must be completing on this very edge for the new one to follow it.
    assign seq_ok = a_vld && HREADY && !err_hold
                 && (cmd_write == a_write) && (cmd_size == a_size)
                 && (cmd_addr == a_addr + (P_AW'(1) << cmd_size))
                 && same_boundary_region(64'(cmd_addr), 64'(a_addr));
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_vld    <= 1'b0;
            a_addr   <= '0;
            a_write  <= 1'b0;
            a_size   <= '0;
            a_wdata  <= '0;
            err_hold <= 1'b0;
`ifdef AHB_MST_SEQ_EN
            a_seq    <= 1'b0;
            a_incr   <= 1'b0;
`endif
        end else if (err_hold) begin
            // The held address phase was masked by IDLE, so it stays put and is reissued afresh.
            if (HREADY) begin
                err_hold <= 1'b0;
`ifdef AHB_MST_SEQ_EN
                a_seq    <= 1'b0;
`endif
            end
        end else begin
            if (accept) begin
                a_vld   <= 1'b1;
                a_addr  <= cmd_addr;
                a_write <= cmd_write;
                a_size  <= cmd_size;
                a_wdata <= cmd_wdata;
`ifdef AHB_MST_SEQ_EN
                a_seq   <= seq_ok;
                a_incr  <= 1'b1;
`endif
            end else if (HREADY) begin
                a_vld <= 1'b0;
            end
            if (d_vld && !HREADY && (HRESP != HRESP_OKAY)) begin
                err_hold <= 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            d_vld   <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= '0;
        end else if (HREADY) begin
            if (err_hold) begin
                d_vld <= 1'b0;
            end else begin
                d_vld   <= a_vld;
                d_write <= a_write;
                d_wdata <= a_wdata;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= d_done;
            if (d_done) begin
                rsp_rdata <= d_write ? '0 : HRDATA;
                rsp_err   <= (HRESP != HRESP_OKAY);
            end
        end
    end

    always_comb begin
        HADDR  = a_addr;
        HWRITE = a_write;
        HSIZE  = a_size;
        HTRANS = HTRANS_IDLE;
        HBURST = HBURST_SINGLE;
        HWDATA = '0;
        if (a_vld && !err_hold) begin
`ifdef AHB_MST_SEQ_EN
            HTRANS = a_seq ? HTRANS_SEQ : HTRANS_NONSEQ;
`else
            HTRANS = HTRANS_NONSEQ;
`endif
        end
`ifdef AHB_MST_SEQ_EN
        if (a_incr) begin
            HBURST = HBURST_INCR;
        end
`endif
        if (d_vld && d_write) begin
            HWDATA = d_wdata;
        end
    end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: scoreboard bench with a memory slave model (wait states, ERROR injection).
// Expectations for the SEQ/INCR case follow AHB_MST_SEQ_EN.
module tb_ahb_cmd_master;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADY;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } sb_t;

    typedef struct {
        int          cyc;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic        hready;
        logic [1:0]  hresp;
    } trace_t;

    sb_t    sb[$];
    trace_t traceQ[$];
    trace_t actQ[$];
    int     numChecks = 0;
    int     numPassed = 0;
    int     cyc = 0;
    logic   traceOn = 1'b0;
    logic   stabOn = 1'b0;

    // Slave model state
    logic [31:0] mem [0:1023];
    logic        sDp;
    logic        sWrite;
    logic        sErr;
    logic        sErrPhase;
    logic [31:0] sAddr;
    logic [2:0]  sSize;
    int          sWait;
    int          waitStates = 0;
    logic        errEn = 1'b0;
    logic [31:0] errAddr = 32'h100;

    ahb_cmd_master #(.P_AW(32), .P_DW(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP),
        .HREADY(HREADY)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic logic [3:0] laneMask(input logic [31:0] addr, input logic [2:0] size);
        if (size == 3'b000) return 4'b0001 << addr[1:0];
        if (size == 3'b001) return 4'b0011 << {addr[1], 1'b0};
        return 4'b1111;
    endfunction

    // Slave: two-cycle ERROR on errAddr, otherwise waitStates low cycles then OKAY.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 2'b00;
        HRDATA = '0;
        if (sDp) begin
            if (sErr) begin
                HRESP  = 2'b01;
                HREADY = sErrPhase;
            end else if (sWait != 0) begin
                HREADY = 1'b0;
            end else if (!sWrite) begin
                HRDATA = mem[sAddr[11:2]];
            end
        end
    end

    always @(posedge HCLK) begin
        logic [31:0] word;
        logic [3:0]  m;
        if (HRESET) begin
            sDp       <= 1'b0;
            sErr      <= 1'b0;
            sErrPhase <= 1'b0;
            sWait     <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | i;
        end else if (HREADY) begin
            if (sDp && sWrite && !sErr) begin
                word = mem[sAddr[11:2]];
                m = laneMask(sAddr, sSize);
                for (int b = 0; b < 4; b++) if (m[b]) word[b*8 +: 8] = HWDATA[b*8 +: 8];
                mem[sAddr[11:2]] <= word;
            end
            sDp       <= HTRANS[1];
            sAddr     <= HADDR;
            sWrite    <= HWRITE;
            sSize     <= HSIZE;
            sWait     <= waitStates;
            sErr      <= errEn && (HADDR == errAddr);
            sErrPhase <= 1'b0;
        end else begin
            if (sWait != 0) sWait <= sWait - 1;
            if (sErr) sErrPhase <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual === expected) numPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    endtask

    // Response scoreboard
    always @(negedge HCLK) begin
        sb_t e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err", rsp_err, e.err);
                if (e.due >= 0) checkOutput("rsp_latency", cyc, e.due);
            end
        end
    end

    // Bus trace and wait-state stability monitor
    logic [1:0]  prevHtrans;
    logic [31:0] prevHaddr;
    logic        prevHready = 1'b1;
    always @(negedge HCLK) begin
        if (traceOn) traceQ.push_back('{cyc, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HREADY, HRESP});
        if (stabOn) begin
            if (!prevHready && prevHtrans != 2'b00) begin
                checkOutput("wait_htrans_hold", HTRANS, prevHtrans);
                checkOutput("wait_haddr_hold", HADDR, prevHaddr);
            end
            if (!HREADY && HTRANS != 2'b00) checkOutput("wait_cmd_ready", cmd_ready, 1'b0);
        end
        prevHtrans = HTRANS;
        prevHaddr  = HADDR;
        prevHready = HREADY;
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic expectRsp,
                                 input logic [31:0] expRdata, input logic expErr, input logic checkLat);
        int waited;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_write = write;
        cmd_size  = size;
        cmd_wdata = wdata;
        @(negedge HCLK);
        while (!cmd_ready && waited < 50) begin
            waited++;
            @(negedge HCLK);
        end
        if (!cmd_ready) begin
            checkOutput("accept_timeout", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        if (expectRsp) sb.push_back('{expRdata, expErr, checkLat ? cyc + 3 : -1});
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        checkOutput("drain", sb.size(), 0);
        repeat (2) @(negedge HCLK);
        @(posedge HCLK);
        #1;
    endtask

    task automatic buildActive();
        actQ.delete();
        foreach (traceQ[i]) if (traceQ[i].htrans != 2'b00) actQ.push_back(traceQ[i]);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ei;
        int ri;
        HRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_size  = '0;
        cmd_wdata = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checkOutput("rst_htrans", HTRANS, HTRANS_IDLE);
        checkOutput("rst_haddr", HADDR, 0);
        checkOutput("rst_hwrite", HWRITE, 0);
        checkOutput("rst_hburst", HBURST, HBURST_SINGLE);
        checkOutput("rst_hwdata", HWDATA, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;

        $display("[TB] zero-wait write then read back-to-back");
        traceQ.delete();
        traceOn = 1'b1;
        applyStimulus(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(32'h10, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        waitDrain();
        traceOn = 1'b0;
        buildActive();
        checkOutput("t1_active_cycles", actQ.size(), 2);
        if (actQ.size() >= 2) begin
            checkOutput("t1_htrans0", actQ[0].htrans, HTRANS_NONSEQ);
            checkOutput("t1_htrans1", actQ[1].htrans, HTRANS_NONSEQ);
            checkOutput("t1_back_to_back", actQ[1].cyc - actQ[0].cyc, 1);
            checkOutput("t1_hwrite0", actQ[0].hwrite, 1'b1);
            checkOutput("t1_haddr1", actQ[1].haddr, 32'h10);
`ifndef AHB_MST_SEQ_EN
            checkOutput("t1_hburst1", actQ[1].hburst, HBURST_SINGLE);
`endif
        end

        $display("[TB] three wait states, four queued reads");
        waitStates = 3;
        stabOn = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(32'h20 + 4 * i, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 32'hC0DE0008 + i, 1'b0, 1'b0);
        waitDrain();
        stabOn = 1'b0;
        waitStates = 0;

        $display("[TB] ERROR response with a queued read behind it");
        errEn = 1'b1;
        traceQ.delete();
        traceOn = 1'b1;
        applyStimulus(32'h100, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        applyStimulus(32'h104, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 32'hC0DE0041, 1'b0, 1'b0);
        waitDrain();
        traceOn = 1'b0;
        errEn = 1'b0;
        ei = -1;
        ri = -1;
        foreach (traceQ[i]) if (ei < 0 && traceQ[i].hresp == 2'b01 && !traceQ[i].hready) ei = i;
        checkOutput("t4_error_seen", ei >= 0, 1'b1);
        if (ei >= 0 && ei + 1 < traceQ.size()) begin
            checkOutput("t4_idle_after_err", traceQ[ei+1].htrans, HTRANS_IDLE);
            for (int i = ei + 2; i < traceQ.size(); i++) if (ri < 0 && traceQ[i].htrans != 2'b00) ri = i;
            checkOutput("t4_reissue_seen", ri >= 0, 1'b1);
            if (ri >= 0) begin
                checkOutput("t4_reissue_htrans", traceQ[ri].htrans, HTRANS_NONSEQ);
                checkOutput("t4_reissue_haddr", traceQ[ri].haddr, 32'h104);
            end
        end

        $display("[TB] byte-lane writes then word read");
        traceQ.delete();
        traceOn = 1'b1;
        applyStimulus(32'h0, 1'b1, HSIZE_WORD, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(32'h3, 1'b1, HSIZE_BYTE, 32'h11000000, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(32'h1, 1'b1, HSIZE_BYTE, 32'h00002200, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 32'h11002200, 1'b0, 1'b1);
        waitDrain();
        traceOn = 1'b0;
        buildActive();
        checkOutput("t5_active_cycles", actQ.size(), 4);
        if (actQ.size() >= 2) begin
            checkOutput("t5_hsize_byte", actQ[1].hsize, HSIZE_BYTE);
            checkOutput("t5_haddr_byte", actQ[1].haddr, 32'h3);
        end

        $display("[TB] reset during a waited data phase");
        waitStates = 3;
        applyStimulus(32'h40, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge HCLK);
        @(negedge HCLK);
        checkOutput("t6_in_wait", HREADY, 1'b0);
        HRESET = 1'b1;
        @(negedge HCLK);
        checkOutput("t6_rst_htrans", HTRANS, HTRANS_IDLE);
        checkOutput("t6_rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("t6_rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge HCLK);
        checkOutput("t6_rst_rsp_valid2", rsp_valid, 1'b0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        waitStates = 0;
        @(posedge HCLK);
        #1;
        applyStimulus(32'h44, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 32'hC0DE0011, 1'b0, 1'b1);
        waitDrain();

        $display("[TB] consecutive word writes across a 1 KB boundary");
        traceQ.delete();
        traceOn = 1'b1;
        applyStimulus(32'h3F8, 1'b1, HSIZE_WORD, 32'hA1, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(32'h3FC, 1'b1, HSIZE_WORD, 32'hA2, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(32'h400, 1'b1, HSIZE_WORD, 32'hA3, 1'b1, 32'h0, 1'b0, 1'b1);
        waitDrain();
        traceOn = 1'b0;
        buildActive();
        checkOutput("t7_active_cycles", actQ.size(), 3);
        if (actQ.size() >= 3) begin
            checkOutput("t7_htrans0", actQ[0].htrans, HTRANS_NONSEQ);
`ifdef AHB_MST_SEQ_EN
            checkOutput("t7_htrans1", actQ[1].htrans, HTRANS_SEQ);
            checkOutput("t7_hburst0", actQ[0].hburst, HBURST_INCR);
            checkOutput("t7_hburst1", actQ[1].hburst, HBURST_INCR);
            checkOutput("t7_hburst2", actQ[2].hburst, HBURST_INCR);
`else
            checkOutput("t7_htrans1", actQ[1].htrans, HTRANS_NONSEQ);
            checkOutput("t7_hburst0", actQ[0].hburst, HBURST_SINGLE);
            checkOutput("t7_hburst1", actQ[1].hburst, HBURST_SINGLE);
            checkOutput("t7_hburst2", actQ[2].hburst, HBURST_SINGLE);
`endif
            checkOutput("t7_htrans2", actQ[2].htrans, HTRANS_NONSEQ);
            checkOutput("t7_haddr2", actQ[2].haddr, 32'h400);
        end

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
